// File: rtl/mux_stage_skid.sv
// mux_stage_skid: registered valid/ready stage with 2-entry skid buffer after the source-select mux.
// Out-of-range selects are consumed, dropped and counted in a saturating error counter.
module mux_stage_skid #(
  parameter int WIDTH   = 16,
  parameter int SEL_W   = 3,
  parameter int NUM_SRC = 6,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [ERR_W-1:0] err_count,
  output logic             err_flag
);
  logic [WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [SEL_W-1:0] main_sel_q, main_sel_d, skid_sel_q, skid_sel_d;
  logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic             in_ready_q;
  logic [ERR_W-1:0] err_count_q, err_count_d, err_base;
  logic             err_flag_q, err_flag_d;
  logic             accept, bad, store, pop;
  assign accept = in_valid & in_ready_q;
  assign bad    = in_sel >= SEL_W'(NUM_SRC);
  assign store  = accept & ~bad;
  assign pop    = main_valid_q & out_ready;
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_sel_d   = main_sel_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;
    if (!main_valid_q || pop) begin
      main_valid_d = skid_valid_q | store;
      main_data_d  = skid_valid_q ? skid_data_q : store ? in_data : main_data_q;
      main_sel_d   = skid_valid_q ? skid_sel_q : store ? in_sel : main_sel_q;
      skid_valid_d = 1'b0;
    end else if (store) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_sel_d   = in_sel;
    end
  end
  // clear applies before the count so a same-cycle error leaves a count of 1
  always_comb begin
    err_base    = clr_err ? '0 : err_count_q;
    err_count_d = (accept && bad && err_base != '1) ? err_base + 1'b1 : err_base;
    err_flag_d  = (~clr_err & err_flag_q) | (accept & bad);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_sel_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      in_ready_q   <= 1'b1;
      err_count_q  <= '0;
      err_flag_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_sel_q   <= main_sel_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      in_ready_q   <= ~skid_valid_d;
      err_count_q  <= err_count_d;
      err_flag_q   <= err_flag_d;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign err_count = err_count_q;
  assign err_flag  = err_flag_q;
endmodule

// File: tb/tb_mux_stage_skid.sv
// tb_mux_stage_skid: scoreboard bench for mux_stage_skid.
module tb_mux_stage_skid;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic [2:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic [2:0]  out_sel;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        clr_err = 1'b0;
  logic [7:0]  err_count;
  logic        err_flag;
  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  logic [18:0] sb_q[$];
  mux_stage_skid dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .clr_err(clr_err), .err_count(err_count), .err_flag(err_flag)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // sample mid-cycle: inputs and outputs here are what the next rising edge will see
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready && in_sel < 3'd6) sb_q.push_back({in_sel, in_data});
    if (rst_n && out_valid && out_ready) begin
      pops++;
      if (sb_q.size() == 0) chk("extra_out", {13'd0, out_sel, out_data}, 32'hdead);
      else chk("out_word", {13'd0, out_sel, out_data}, {13'd0, sb_q.pop_front()});
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] d, input logic [2:0] s);
    logic ok;
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      if (n > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask
  initial begin
    step(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_err_count", err_count, 0);
    chk("rst_err_flag", err_flag, 0);
    chk("rst_out_data", {out_sel, out_data}, 0);
    step(1);
    out_ready = 1'b1;
    send(16'h1234, 3'd2);
    chk("lat_valid", out_valid, 1);
    chk("lat_data", {out_sel, out_data}, {3'd2, 16'h1234});
    step(1);
    chk("lat_drop", out_valid, 0);
    for (int i = 1; i <= 8; i++) begin
      send(16'(i), 3'((i - 1) % 6));
      chk("stream_ready", in_ready, 1);
    end
    step(3);
    chk("stream_pops", pops, 9);
    out_ready = 1'b0;
    send(16'hAAAA, 3'd1);
    send(16'hBBBB, 3'd3);
    in_data  = 16'hCCCC;
    in_sel   = 3'd5;
    in_valid = 1'b1;
    @(negedge clk);
    chk("full_ready", in_ready, 0);
    step(3);
    chk("stall_hold", {out_sel, out_data}, {3'd1, 16'hAAAA});
    chk("stall_ready", in_ready, 0);
    out_ready = 1'b1;
    send(16'hCCCC, 3'd5);
    step(3);
    chk("skid_pops", pops, 12);
    send(16'h0011, 3'd1);
    send(16'h0022, 3'd6);
    send(16'h0033, 3'd7);
    send(16'h0044, 3'd0);
    step(2);
    chk("err_two", err_count, 2);
    chk("err_flag", err_flag, 1);
    chk("err_pops", pops, 14);
    for (int i = 0; i < 300; i++) send(16'(i), 3'd7);
    chk("err_sat", err_count, 255);
    clr_err = 1'b1;
    send(16'h0055, 3'd7);
    clr_err = 1'b0;
    chk("clr_cnt_count", err_count, 1);
    chk("clr_cnt_flag", err_flag, 1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("clr_count", err_count, 0);
    chk("clr_flag", err_flag, 0);
    send(16'h0066, 3'd7);
    out_ready = 1'b0;
    send(16'h0005, 3'd1);
    send(16'h0006, 3'd2);
    @(negedge clk);
    chk("pre_rst_ready", in_ready, 0);
    chk("pre_rst_err", err_count, 1);
    step(0);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    sb_q.delete();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_err", err_count, 0);
    out_ready = 1'b1;
    step(5);
    chk("no_stale", pops, 14);
    send(16'h0077, 3'd4);
    step(2);
    chk("final_pops", pops, 15);
    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
